// File: rtl/layer2_sched_pkg.sv
// Shared types and helpers for the layer-2 neuron scheduler: FSM state encoding,
// default sizing constants and the saturating add used by the membrane update.
package layer2_sched_pkg;

    localparam int N_DEF      = 10;
    localparam int VWIDTH_DEF = 12;
    localparam int THRESH_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_ACC  = 2'd2,
        ST_DONE = 2'd3
    } sched_state_e;

    // Operands must already lie inside the vw-bit signed range; result is clamped to it.
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int vw);
        logic signed [32:0] sum;
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        sum = {a[31], a} + {b[31], b};
        hi  = (33'sd1 <<< (vw - 1)) - 33'sd1;
        lo  = -(33'sd1 <<< (vw - 1));
        if (sum > hi)
            sat_add = hi[31:0];
        else if (sum < lo)
            sat_add = lo[31:0];
        else
            sat_add = sum[31:0];
    endfunction

endpackage

// File: rtl/lif_update.sv
// Combinational membrane update for one neuron: saturating integrate, threshold compare.
// Define L2_LEAK_EN to apply an arithmetic-shift leak to the base potential first.
module lif_update
    import layer2_sched_pkg::*;
#(
    parameter int VWIDTH     = VWIDTH_DEF,
    parameter int LEAK_SHIFT = 3
) (
    input  logic signed [VWIDTH-1:0] v,
    input  logic signed [7:0]        mac_out,
    input  logic signed [VWIDTH-1:0] thresh,
    output logic signed [VWIDTH-1:0] v_next,
    output logic                     fire
);

    logic signed [VWIDTH-1:0] v_base;
    logic signed [31:0]       base_w;
    logic signed [31:0]       mac_w;
    logic signed [VWIDTH-1:0] v_sat;

`ifdef L2_LEAK_EN
    assign v_base = v - (v >>> LEAK_SHIFT);
`else
    assign v_base = v;
`endif

    assign base_w = {{(32-VWIDTH){v_base[VWIDTH-1]}}, v_base};
    assign mac_w  = {{24{mac_out[7]}}, mac_out};
    assign v_sat  = VWIDTH'(sat_add(base_w, mac_w, VWIDTH));
    assign fire   = (v_sat >= thresh);
    assign v_next = fire ? '0 : v_sat;

endmodule

// File: rtl/layer2_neuron_scheduler.sv
// Time-multiplexes one layer-2 MAC across N neurons, integrating each result into a
// per-neuron membrane register. Leak behaviour is selected by L2_LEAK_EN (see lif_update).
//
// state | meaning
// IDLE  | wait for start; clear zeroes potentials
// ADDR  | present neuron idx to the parameter ROM
// ACC   | ROM data valid, integrate mac_out into v[idx]
// DONE  | spikes_out valid, done pulse
module layer2_neuron_scheduler
    import layer2_sched_pkg::*;
#(
    parameter int S          = 25,
    parameter int WIDTH      = 8,
    parameter int N          = N_DEF,
    parameter int ADDR_W     = 4,
    parameter int VWIDTH     = VWIDTH_DEF,
    parameter int THRESH     = THRESH_DEF,
    parameter int LEAK_SHIFT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  clear,
    input  logic [S-1:0]          spikes_in,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W-1:0]     rom_addr,
    input  logic [S*WIDTH+7:0]    rom_data,
    output logic [S-1:0]          mac_pixels,
    output logic [S*WIDTH-1:0]    mac_weights,
    output logic [7:0]            mac_bias,
    input  logic signed [7:0]     mac_out,
    output logic [N-1:0]          spikes_out
);

    localparam logic [1:0] IDLE = 2'(ST_IDLE);
    localparam logic [1:0] ADDR = 2'(ST_ADDR);
    localparam logic [1:0] ACC  = 2'(ST_ACC);
    localparam logic [1:0] DONE = 2'(ST_DONE);

    localparam logic signed [VWIDTH-1:0] THRESH_V = VWIDTH'(THRESH);
    localparam logic [ADDR_W-1:0]        LAST_IDX = ADDR_W'(N - 1);

    logic [1:0]               state;
    logic [ADDR_W-1:0]        idx;
    logic [S-1:0]             pix_q;
    logic [N-1:0]             shadow;
    logic [N-1:0]             shadow_upd;
    logic signed [VWIDTH-1:0] v_mem [N];
    logic signed [VWIDTH-1:0] v_next;
    logic                     fire;

    lif_update #(
        .VWIDTH     (VWIDTH),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) u_lif (
        .v       (v_mem[idx]),
        .mac_out (mac_out),
        .thresh  (THRESH_V),
        .v_next  (v_next),
        .fire    (fire)
    );

    // Includes the current neuron's fire so spikes_out is complete on entry to DONE.
    always_comb begin
        shadow_upd = shadow;
        if (fire)
            shadow_upd[idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            pix_q      <= '0;
            shadow     <= '0;
            spikes_out <= '0;
            for (int i = 0; i < N; i++)
                v_mem[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear) begin
                        for (int i = 0; i < N; i++)
                            v_mem[i] <= '0;
                    end
                    if (start) begin
                        pix_q  <= spikes_in;
                        idx    <= '0;
                        shadow <= '0;
                        state  <= ADDR;
                    end
                end
                ADDR: state <= ACC;
                ACC: begin
                    v_mem[idx] <= v_next;
                    shadow     <= shadow_upd;
                    if (idx == LAST_IDX) begin
                        spikes_out <= shadow_upd;
                        state      <= DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= ADDR;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign rom_addr    = idx;
    assign mac_pixels  = pix_q;
    assign mac_weights = rom_data[S*WIDTH-1:0];
    assign mac_bias    = rom_data[S*WIDTH +: 8];

endmodule

// File: tb/tb_layer2_neuron_scheduler.sv
// Directed bench for layer2_neuron_scheduler (default build, no leak): the bench
// plays the MAC with a per-neuron result table indexed by rom_addr.
module tb_layer2_neuron_scheduler;

    localparam int S      = 25;
    localparam int WIDTH  = 8;
    localparam int N      = 10;
    localparam int ADDR_W = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 clear;
    logic [S-1:0]         spikes_in;
    logic                 busy;
    logic                 done;
    logic [ADDR_W-1:0]    rom_addr;
    logic [S*WIDTH+7:0]   rom_data;
    logic [S-1:0]         mac_pixels;
    logic [S*WIDTH-1:0]   mac_weights;
    logic [7:0]           mac_bias;
    logic signed [7:0]    mac_out;
    logic [N-1:0]         spikes_out;

    logic signed [7:0]    mac_tab [16];
    logic [S-1:0]         pix_pat;
    int                   n_tests = 0;
    int                   n_fail  = 0;

    layer2_neuron_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .clear       (clear),
        .spikes_in   (spikes_in),
        .busy        (busy),
        .done        (done),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .mac_pixels  (mac_pixels),
        .mac_weights (mac_weights),
        .mac_bias    (mac_bias),
        .mac_out     (mac_out),
        .spikes_out  (spikes_out)
    );

    always #5 clk = ~clk;

    assign mac_out = mac_tab[rom_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_mac(input logic signed [7:0] m);
        for (int i = 0; i < 16; i++)
            mac_tab[i] = m;
    endtask

    task automatic pulse_clear();
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
    endtask

    // One timestep; returns cycles from the accept edge to the done cycle and spikes_out.
    task automatic run_step(input logic clr, input bit chk_seq,
                            output int cyc, output logic [N-1:0] spk);
        @(negedge clk);
        start = 1'b1; clear = clr; spikes_in = pix_pat;
        @(negedge clk);
        start = 1'b0; clear = 1'b0; spikes_in = ~pix_pat;
        cyc = 0;
        while (done !== 1'b1 && cyc < 60) begin
            if (chk_seq) begin
                chk($sformatf("addr_k%0d", cyc), 32'(rom_addr), cyc / 2);
                chk($sformatf("busy_k%0d", cyc), 32'(busy), 1);
            end
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 60)
            chk("step_timeout", cyc, 2 * N);
        spk = spikes_out;
        if (chk_seq) begin
            chk("pixels_latched", 32'(mac_pixels), 32'(pix_pat));
            @(negedge clk);
            chk("done_one_cycle", 32'(done), 0);
            chk("idle_after_done", 32'(busy), 0);
            chk("spikes_hold", 32'(spikes_out), 32'(spk));
        end
    endtask

    initial begin
        int            cyc;
        int            done_cnt;
        logic [N-1:0]  spk;
        logic [S*WIDTH-1:0] wexp;

        rst = 1'b1; start = 1'b0; clear = 1'b0; spikes_in = '0;
        rom_data = '0; pix_pat = 25'h1A5_5A5A;
        set_mac(8'sd0);

        repeat (3) @(negedge clk);
        chk("rst_busy",     32'(busy), 0);
        chk("rst_done",     32'(done), 0);
        chk("rst_spikes",   32'(spikes_out), 0);
        chk("rst_rom_addr", 32'(rom_addr), 0);
        chk("rst_pixels",   32'(mac_pixels), 0);
        rst = 1'b0;

        wexp = {8{25'h0F0_1234}};
        rom_data = {8'hA5, wexp};
        #1;
        chk("bias_pass", 32'(mac_bias), 32'hA5);
        chk("weights_pass", 32'(mac_weights === wexp), 1);
        rom_data = {8'h3C, ~wexp};
        #1;
        chk("bias_pass2", 32'(mac_bias), 32'h3C);
        chk("weights_pass2", 32'(mac_weights === ~wexp), 1);

        // +10 per step: 70 >= 64 on step 7, then potentials restart from 0 (fire on 14).
        set_mac(8'sd10);
        for (int t = 1; t <= 14; t++) begin
            run_step(1'b0, t == 1, cyc, spk);
            if (t == 1)
                chk("latency", cyc, 2 * N);
            chk($sformatf("int_step%0d", t), 32'(spk), (t == 7 || t == 14) ? 32'h3FF : 32'h0);
        end

        // Per-neuron results: exactly 64 fires, 63 does not.
        pulse_clear();
        for (int i = 0; i < 16; i++)
            mac_tab[i] = 8'(8 * i);
        mac_tab[7] = 8'sd63;
        run_step(1'b0, 1'b0, cyc, spk);
        chk("thresh_boundary", 32'(spk), 32'h300);

        // Reset during neuron 4's ACC with neurons 5..9 holding 30.
        pulse_clear();
        for (int i = 0; i < 16; i++)
            mac_tab[i] = (i < 5) ? 8'sd64 : 8'sd30;
        run_step(1'b0, 1'b0, cyc, spk);
        chk("pre_rst_spikes", 32'(spk), 32'h01F);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (9) @(negedge clk);
        chk("rst_mid_addr", 32'(rom_addr), 4);
        rst = 1'b1;
        #1;
        chk("rst_mid_busy",   32'(busy), 0);
        chk("rst_mid_spikes", 32'(spikes_out), 0);
        chk("rst_mid_done",   32'(done), 0);
        @(negedge clk); rst = 1'b0;
        set_mac(8'sd40);
        run_step(1'b0, 1'b0, cyc, spk);
        chk("post_rst_step1", 32'(spk), 32'h0);
        run_step(1'b0, 1'b0, cyc, spk);
        chk("post_rst_step2", 32'(spk), 32'h3FF);

        // Negative saturation at -2048, then +127 needs 17 steps to reach 111.
        pulse_clear();
        set_mac(-8'sd128);
        for (int t = 1; t <= 20; t++) begin
            run_step(1'b0, 1'b0, cyc, spk);
            chk($sformatf("neg_step%0d", t), 32'(spk), 32'h0);
        end
        set_mac(8'sd127);
        for (int t = 1; t <= 17; t++) begin
            run_step(1'b0, 1'b0, cyc, spk);
            chk($sformatf("rise_step%0d", t), 32'(spk), (t == 17) ? 32'h3FF : 32'h0);
        end

        // start+clear while busy are ignored: 40 + 40 fires, single done.
        set_mac(8'sd40);
        run_step(1'b0, 1'b0, cyc, spk);
        chk("busy_pre", 32'(spk), 32'h0);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            start = (k == 5);
            clear = (k == 5);
            if (done === 1'b1)
                done_cnt++;
            @(negedge clk);
        end
        start = 1'b0; clear = 1'b0;
        chk("busy_done_count", done_cnt, 1);
        chk("busy_ignore_spikes", 32'(spikes_out), 32'h3FF);

        // start+clear in IDLE with 40 preloaded integrates from zero.
        run_step(1'b0, 1'b0, cyc, spk);
        chk("preload", 32'(spk), 32'h0);
        run_step(1'b1, 1'b0, cyc, spk);
        chk("start_clear", 32'(spk), 32'h0);
        run_step(1'b0, 1'b0, cyc, spk);
        chk("after_start_clear", 32'(spk), 32'h3FF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/layer2_neuron_scheduler.md
# layer2_neuron_scheduler

Time-multiplexing controller that shares one 25-input layer-2 MAC-plus-bias datapath across all layer-2 neurons. On each timestep it fetches every neuron's packed bias and weights from a parameter ROM, drives them with the latched layer-1 spike vector into the MAC, and integrates each result into that neuron's membrane potential. It then emits the layer-2 spike vector. It sits between the layer-1 spike output and the layer-2 output/readout logic.

## Interface
Parameters:
- S, 25, synaptic inputs per neuron (layer-1 spike width)
- WIDTH, 8, weight width in bits
- N, 10, number of layer-2 neurons sharing the MAC
- ADDR_W, 4, ROM address width; must satisfy 2^ADDR_W ≥ N
- VWIDTH, 12, signed membrane-potential width
- THRESH, 64, firing threshold (signed, VWIDTH bits)
- LEAK_SHIFT, 3, leak shift amount (used only with the leak feature)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin one timestep; accepted only in IDLE
- clear  in  1  zero all membrane potentials; accepted only in IDLE
- spikes_in  in  S  layer-1 spike vector; latched on accepted start
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse; spikes_out valid from this cycle
- rom_addr  out  ADDR_W  neuron index being fetched
- rom_data  in  S*WIDTH+8  {bias[7:0], weights}; valid one cycle after rom_addr
- mac_pixels  out  S  latched spike vector to MAC
- mac_weights  out  S*WIDTH  weights to MAC (rom_data[S*WIDTH-1:0], passthrough)
- mac_bias  out  8  bias to MAC (rom_data[S*WIDTH+7:S*WIDTH], passthrough)
- mac_out  in  8  signed MAC+bias result, combinational from mac_* outputs
- spikes_out  out  N  registered layer-2 spike vector, bit i = neuron i

## Operation
- States: IDLE, ADDR, ACC, DONE.
- IDLE:
  - clear=1 zeroes all N potentials.
  - start=1 latches spikes_in, sets idx=0 and goes to ADDR.
  - If start and clear are both high, clear applies first, so the timestep integrates from zero.
- ADDR: rom_addr=idx; go to ACC.
- ACC: rom_data is valid and mac_out is sampled.
  - Compute v' = sat(v[idx] + sext(mac_out)).
  - If v' ≥ THRESH: set spike bit idx and write v[idx]=0. Otherwise write v[idx]=v'.
  - If idx==N-1, go to DONE. Otherwise idx++ and go to ADDR.
- DONE: copy the spike shadow to spikes_out, pulse done, return to IDLE.
- The shadow spike vector is cleared on start.
- Arithmetic:
  - mac_out is sign-extended to VWIDTH.
  - sat() clamps to [-2^(VWIDTH-1), 2^(VWIDTH-1)-1].
  - Potentials persist across timesteps until clear or rst.
- start or clear while busy is ignored (no queueing).
- rst (async, any state): state=IDLE, idx=0, all potentials=0, spikes_out=0, busy=0, done=0, latched spikes=0.

## Timing
- Reset values: rom_addr=0, mac_pixels=0, spikes_out=0, busy=0, done=0. mac_weights and mac_bias follow rom_data.
- Per neuron: 2 cycles (ADDR, ACC).
- Latency: start accepted at edge T; done high during cycle T+2N+1 (T+21 for N=10).
- The next start is accepted in the cycle after done.
- Minimum timestep period: 2N+2 cycles.
- spikes_out changes only on the DONE edge.

## Configuration
- L2_LEAK_EN defined: in ACC, the base potential is leaked before integration: v' = sat(v - (v >>> LEAK_SHIFT) + sext(mac_out)), using an arithmetic shift.
- L2_LEAK_EN undefined: pure integrate-and-fire, with no leak logic present.

## Structure
- Package layer2_sched_pkg contains the state enum type, the saturating-add function, and default constants for N, VWIDTH and THRESH.
- Sub-module lif_update: combinational block with inputs v, mac_out and THRESH, and outputs v_next and fire. The leak path lives here under L2_LEAK_EN.
- The potential array is a register file of N×VWIDTH flops.

## Test plan
- Reset mid-timestep: assert rst during neuron 4's ACC → busy=0, spikes_out=0, and a following timestep starts from zero potentials.
- Basic integration (no leak): mac_out=+10 for all neurons, THRESH=64:
  - Timesteps 1–6 → spikes_out=0.
  - Timestep 7 → spikes_out=10'h3FF and all potentials reset to 0.
- Latency and addressing: one start → rom_addr sequence 0..9, with each address held one cycle and then ACC. done pulses exactly 21 cycles after start, for one cycle.
- Saturation: mac_out=-128 for 20 timesteps → potential clamps at -2048 with no wrap. Then mac_out=+127 → no spike until the potential crosses 64.
- Handshake edge cases:
  - start during busy → ignored, no extra done.
  - start+clear in IDLE with preloaded potentials → result equals integration from zero.
- L2_LEAK_EN build: potential 80 with mac_out=0 and LEAK_SHIFT=3 → 70 after one timestep, 62 after the next (80→70→62), no spike.
